// File: rtl/crtc_reg_writer.sv
// Sequencer that turns cursor/shape/control/raw requests into timed CRTC register
// bus write cycles, keeping shadow copies of the write-only registers.
module crtc_reg_writer #(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [15:0] req_data,
    output logic        done,
    output logic [7:0]  cpu_data,
    output logic [1:0]  cpu_address,
    output logic        n_write,
    output logic        data_oe,
    output logic [10:0] shadow_match_address,
    output logic        shadow_cursor_disable,
    output logic [3:0]  shadow_start_scanline,
    output logic [3:0]  shadow_end_scanline,
    output logic        shadow_screen_blank,
    output logic        shadow_extended_bg_colours
);

    localparam int MAX_CYCLES = (SETUP_CYCLES > PULSE_CYCLES)
                              ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                              : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
    localparam int CNT_W = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic             HOLD_IS_ONE = (HOLD_CYCLES == 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_req_ready;
    logic             r_done;
    logic [7:0]       r_cpu_data;
    logic [1:0]       r_cpu_address;
    logic             r_n_write;
    logic             r_data_oe;
    logic             r_second_pending;
    logic [7:0]       r_second_data;
    logic [10:0]      r_match_address;
    logic             r_cursor_disable;
    logic [3:0]       r_start_scanline;
    logic [3:0]       r_end_scanline;
    logic             r_screen_blank;
    logic             r_ext_bg;

    logic       w_accept;
    logic       w_count_zero;
    logic [1:0] w_first_address;
    logic [7:0] w_first_data;
    logic       w_second_pending;
    logic [7:0] w_second_data;
    logic       w_unused;

    assign w_accept     = req_valid && r_req_ready;
    assign w_count_zero = (r_count == '0);
    assign w_unused     = ^req_data[14:11];

    // Request decode: first write of every kind, plus the reg1 write of a cursor position.
    always_comb begin
        w_first_address  = 2'd0;
        w_first_data     = 8'h00;
        w_second_pending = 1'b0;
        w_second_data    = req_data[7:0];
        case (req_kind)
            2'd0: begin
                w_first_address  = 2'd0;
                w_first_data     = {req_data[15], 4'b0000, req_data[10:8]};
                w_second_pending = 1'b1;
            end
            2'd1: begin
                w_first_address = 2'd2;
                w_first_data    = req_data[7:0];
            end
            2'd2: begin
                w_first_address = 2'd3;
                w_first_data    = {3'b000, req_data[4], 3'b000, req_data[0]};
            end
            default: begin
                w_first_address = req_data[9:8];
                w_first_data    = req_data[7:0];
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_count          <= '0;
            r_req_ready      <= 1'b1;
            r_done           <= 1'b0;
            r_cpu_data       <= 8'h00;
            r_cpu_address    <= 2'd0;
            r_n_write        <= 1'b1;
            r_data_oe        <= 1'b0;
            r_second_pending <= 1'b0;
            r_second_data    <= 8'h00;
            r_match_address  <= 11'd0;
            r_cursor_disable <= 1'b0;
            r_start_scanline <= 4'd13;
            r_end_scanline   <= 4'd14;
            r_screen_blank   <= 1'b0;
            r_ext_bg         <= 1'b0;
        end else begin
            // NOTE: done defaults low here so it is a single-cycle pulse without extra clear logic.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state          <= S_SETUP;
                        r_count          <= SETUP_LOAD;
                        r_cpu_address    <= w_first_address;
                        r_cpu_data       <= w_first_data;
                        r_second_pending <= w_second_pending;
                        r_second_data    <= w_second_data;
                        r_data_oe        <= 1'b1;
                        r_req_ready      <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (w_count_zero) begin
                        r_state   <= S_PULSE;
                        r_count   <= PULSE_LOAD;
                        r_n_write <= 1'b0;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (w_count_zero) begin
                        r_state   <= S_HOLD;
                        r_count   <= HOLD_LOAD;
                        r_n_write <= 1'b1;
                        r_done    <= HOLD_IS_ONE && !r_second_pending;
                        // Shadows follow the register file, which latches on this rising strobe.
                        case (r_cpu_address)
                            2'd0: begin
                                r_cursor_disable      <= r_cpu_data[7];
                                r_match_address[10:8] <= r_cpu_data[2:0];
                            end
                            2'd1: r_match_address[7:0] <= r_cpu_data;
                            2'd2: begin
                                r_end_scanline   <= r_cpu_data[7:4];
                                r_start_scanline <= r_cpu_data[3:0];
                            end
                            default: begin
                                r_screen_blank <= r_cpu_data[4];
                                r_ext_bg       <= r_cpu_data[0];
                            end
                        endcase
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                    if (w_count_zero) begin
                        if (r_second_pending) begin
                            r_state          <= S_SETUP;
                            r_count          <= SETUP_LOAD;
                            r_cpu_address    <= 2'd1;
                            r_cpu_data       <= r_second_data;
                            r_second_pending <= 1'b0;
                        end else begin
                            r_state     <= S_IDLE;
                            r_data_oe   <= 1'b0;
                            r_req_ready <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                        r_done  <= (r_count == CNT_W'(1)) && !r_second_pending;
                    end
                end
            endcase
        end
    end

    assign req_ready                  = r_req_ready;
    assign done                       = r_done;
    assign cpu_data                   = r_cpu_data;
    assign cpu_address                = r_cpu_address;
    assign n_write                    = r_n_write;
    assign data_oe                    = r_data_oe;
    assign shadow_match_address       = r_match_address;
    assign shadow_cursor_disable      = r_cursor_disable;
    assign shadow_start_scanline      = r_start_scanline;
    assign shadow_end_scanline        = r_end_scanline;
    assign shadow_screen_blank        = r_screen_blank;
    assign shadow_extended_bg_colours = r_ext_bg;

endmodule

// File: tb/tb_crtc_reg_writer.sv
// Scoreboard bench for crtc_reg_writer: expected bus writes are queued at issue time and
// a negedge monitor reconstructs each write cycle (phase lengths, done) and compares.
module tb_crtc_reg_writer;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] s;
        logic [7:0] p;
        logic [7:0] h;
        logic       dn;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic [1:0]  req_kind;
    logic [15:0] req_data;
    logic        req_ready [2];
    logic        done [2];
    logic [7:0]  cpu_data [2];
    logic [1:0]  cpu_address [2];
    logic        n_write [2];
    logic        data_oe [2];
    logic [10:0] sh_match [2];
    logic        sh_dis [2];
    logic [3:0]  sh_start [2];
    logic [3:0]  sh_end [2];
    logic        sh_blank [2];
    logic        sh_ext [2];

    int compared   = 0;
    int mismatched = 0;

    wr_t q0[$];
    wr_t q1[$];

    int         ph [2]      = '{0, 0};
    logic [7:0] s_cnt [2]   = '{8'd0, 8'd0};
    logic [7:0] p_cnt [2]   = '{8'd0, 8'd0};
    logic [7:0] h_cnt [2]   = '{8'd0, 8'd0};
    logic [1:0] cur_a [2]   = '{2'd0, 2'd0};
    logic [7:0] cur_d [2]   = '{8'd0, 8'd0};
    logic       last_dn [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    crtc_reg_writer u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_kind(req_kind), .req_data(req_data), .done(done[0]),
        .cpu_data(cpu_data[0]), .cpu_address(cpu_address[0]),
        .n_write(n_write[0]), .data_oe(data_oe[0]),
        .shadow_match_address(sh_match[0]), .shadow_cursor_disable(sh_dis[0]),
        .shadow_start_scanline(sh_start[0]), .shadow_end_scanline(sh_end[0]),
        .shadow_screen_blank(sh_blank[0]), .shadow_extended_bg_colours(sh_ext[0])
    );

    crtc_reg_writer #(.SETUP_CYCLES(3), .PULSE_CYCLES(4), .HOLD_CYCLES(2)) u_dut_slow (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_kind(req_kind), .req_data(req_data), .done(done[1]),
        .cpu_data(cpu_data[1]), .cpu_address(cpu_address[1]),
        .n_write(n_write[1]), .data_oe(data_oe[1]),
        .shadow_match_address(sh_match[1]), .shadow_cursor_disable(sh_dis[1]),
        .shadow_start_scanline(sh_start[1]), .shadow_end_scanline(sh_end[1]),
        .shadow_screen_blank(sh_blank[1]), .shadow_extended_bg_colours(sh_ext[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_push(input int k, input wr_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic q_pop(input int k, output wr_t e);
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    // Monitor step: rebuilds one write cycle from bus samples and scores it when its hold ends.
    task automatic mon_step(input int k);
        wr_t   got;
        wr_t   exp;
        logic  changed;
        string tag;
        tag = (k == 0) ? "dut0" : "dut1";
        if (reset) begin
            ph[k] = 0;
        end else begin
            changed = data_oe[k] && ({cpu_address[k], cpu_data[k]} != {cur_a[k], cur_d[k]});
            if (ph[k] == 3 && (!data_oe[k] || changed)) begin
                got = '{addr: cur_a[k], data: cur_d[k], s: s_cnt[k], p: p_cnt[k],
                        h: h_cnt[k], dn: last_dn[k]};
                check({tag, " write expected"}, 64'(q_size(k) > 0), 64'd1);
                if (q_size(k) > 0) begin
                    q_pop(k, exp);
                    check({tag, " write {addr,data,setup,pulse,hold,done}"}, 64'(got), 64'(exp));
                end
                ph[k] = 0;
            end
            if (data_oe[k]) begin
                if (n_write[k]) begin
                    if (ph[k] == 0 || (ph[k] == 1 && changed)) begin
                        ph[k] = 1;
                        s_cnt[k] = 8'd1;
                    end else if (ph[k] == 1) begin
                        s_cnt[k]++;
                    end else if (ph[k] == 2) begin
                        ph[k] = 3;
                        h_cnt[k] = 8'd1;
                    end else begin
                        check({tag, " done only in last hold cycle"}, 64'(last_dn[k]), 64'd0);
                        h_cnt[k]++;
                    end
                end else begin
                    if (ph[k] == 1) begin
                        check({tag, " bus stable at strobe fall"}, 64'(changed), 64'd0);
                        ph[k] = 2;
                        p_cnt[k] = 8'd1;
                    end else if (ph[k] == 2) begin
                        check({tag, " bus stable in pulse"}, 64'(changed), 64'd0);
                        p_cnt[k]++;
                    end else begin
                        check({tag, " strobe only after setup"}, 64'(ph[k]), 64'd1);
                    end
                end
            end else begin
                check({tag, " strobe high while bus idle"}, 64'(n_write[k]), 64'd1);
                if (ph[k] == 1 || ph[k] == 2) check({tag, " write aborted"}, 64'(ph[k]), 64'd0);
                ph[k] = 0;
            end
            if (done[k]) check({tag, " done only in hold"}, 64'(ph[k]), 64'd3);
        end
        cur_a[k]   = cpu_address[k];
        cur_d[k]   = cpu_data[k];
        last_dn[k] = done[k];
    endtask

    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
    end

    // Call just after a negedge; returns at the acceptance edge + 1.
    task automatic send(input int k, input logic [1:0] kind, input logic [15:0] data,
                        input bit keep_valid);
        bit ok;
        ok = 1'b0;
        req_kind     = kind;
        req_data     = data;
        req_valid[k] = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (req_ready[k]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        check("request accepted", 64'(ok), 64'd1);
        if (!keep_valid) req_valid[k] = 1'b0;
    endtask

    task automatic check_shadows(input int k, input string name, input logic [10:0] m,
                                 input logic dis, input logic [3:0] st, input logic [3:0] en,
                                 input logic bl, input logic ex);
        check({name, " shadow_match_address"}, 64'(sh_match[k]), 64'(m));
        check({name, " shadow_cursor_disable"}, 64'(sh_dis[k]), 64'(dis));
        check({name, " shadow_start_scanline"}, 64'(sh_start[k]), 64'(st));
        check({name, " shadow_end_scanline"}, 64'(sh_end[k]), 64'(en));
        check({name, " shadow_screen_blank"}, 64'(sh_blank[k]), 64'(bl));
        check({name, " shadow_extended_bg"}, 64'(sh_ext[k]), 64'(ex));
    endtask

    task automatic check_bus_reset(input int k, input string name);
        check({name, " n_write"}, 64'(n_write[k]), 64'd1);
        check({name, " data_oe"}, 64'(data_oe[k]), 64'd0);
        check({name, " cpu_data"}, 64'(cpu_data[k]), 64'd0);
        check({name, " cpu_address"}, 64'(cpu_address[k]), 64'd0);
        check({name, " req_ready"}, 64'(req_ready[k]), 64'd1);
        check({name, " done"}, 64'(done[k]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_low;
        reset        = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_kind     = 2'd0;
        req_data     = 16'h0000;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_bus_reset(k, "reset");
            check_shadows(k, "reset", 11'd0, 1'b0, 4'd13, 4'd14, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Cursor shape with default timing: strobe low cycles 2-3, done cycle 4, ready cycle 5.
        q_push(0, '{addr: 2'd2, data: 8'h53, s: 8'd1, p: 8'd2, h: 8'd1, dn: 1'b1});
        send(0, 2'd1, 16'h0053, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("shape ready cycle %0d", c), 64'(req_ready[0]), 64'(c == 5));
            check($sformatf("shape n_write cycle %0d", c), 64'(n_write[0]), 64'(!(c == 2 || c == 3)));
            check($sformatf("shape done cycle %0d", c), 64'(done[0]), 64'(c == 4));
        end
        check_shadows(0, "shape", 11'd0, 1'b0, 4'd3, 4'd5, 1'b0, 1'b0);

        // Cursor position: reg0 then reg1 back to back, eight busy cycles.
        @(negedge clk);
        q_push(0, '{addr: 2'd0, data: 8'h85, s: 8'd1, p: 8'd2, h: 8'd1, dn: 1'b0});
        q_push(0, '{addr: 2'd1, data: 8'h67, s: 8'd1, p: 8'd2, h: 8'd1, dn: 1'b1});
        send(0, 2'd0, 16'h8567, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("position ready cycle %0d", c), 64'(req_ready[0]), 64'(c == 9));
        end
        check_shadows(0, "position", 11'h567, 1'b1, 4'd3, 4'd5, 1'b0, 1'b0);

        // Control bits on the 3/4/2 instance.
        @(negedge clk);
        q_push(1, '{addr: 2'd3, data: 8'h11, s: 8'd3, p: 8'd4, h: 8'd2, dn: 1'b1});
        send(1, 2'd2, 16'h0011, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("control ready cycle %0d", c), 64'(req_ready[1]), 64'(c == 10));
        end
        check_shadows(1, "control", 11'd0, 1'b0, 4'd13, 4'd14, 1'b1, 1'b1);

        // Two raw writes with req_valid held high: one IDLE cycle between them.
        @(negedge clk);
        q_push(0, '{addr: 2'd1, data: 8'h42, s: 8'd1, p: 8'd2, h: 8'd1, dn: 1'b1});
        q_push(0, '{addr: 2'd2, data: 8'h99, s: 8'd1, p: 8'd2, h: 8'd1, dn: 1'b1});
        send(0, 2'd3, 16'h0142, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req_data = 16'h0299;
            check($sformatf("b2b ready cycle %0d", c), 64'(req_ready[0]), 64'(c == 5 || c == 10));
            if (c == 9) req_valid[0] = 1'b0;
        end
        check_shadows(0, "b2b", 11'h542, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0);

        // Reset during the reg0 strobe of a cursor position request.
        @(negedge clk);
        send(0, 2'd0, 16'h0123, 1'b0);
        seen_low = 1'b0;
        for (int n = 0; n < 20 && !seen_low; n++) begin
            @(negedge clk);
            if (!n_write[0]) seen_low = 1'b1;
        end
        check("abort reached pulse", 64'(seen_low), 64'd1);
        #2 reset = 1'b1;
        #1;
        q0.delete();
        check("abort n_write", 64'(n_write[0]), 64'd1);
        check("abort data_oe", 64'(data_oe[0]), 64'd0);
        check("abort done", 64'(done[0]), 64'd0);
        check_shadows(0, "abort", 11'd0, 1'b0, 4'd13, 4'd14, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("after abort done", 64'(done[0]), 64'd0);
        q_push(0, '{addr: 2'd0, data: 8'h03, s: 8'd1, p: 8'd2, h: 8'd1, dn: 1'b0});
        q_push(0, '{addr: 2'd1, data: 8'h21, s: 8'd1, p: 8'd2, h: 8'd1, dn: 1'b1});
        send(0, 2'd0, 16'h0321, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("recover ready cycle %0d", c), 64'(req_ready[0]), 64'(c == 9));
        end
        check_shadows(0, "recover", 11'h321, 1'b0, 4'd13, 4'd14, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("dut0 writes outstanding", 64'(q0.size()), 64'd0);
        check("dut1 writes outstanding", 64'(q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/crtc_reg_writer.md
# crtc_reg_writer

Bus-master sequencer that drives the CRTC CPU register bus (8-bit data, 2-bit address, active-low write strobe) from a simple valid/ready request port. It converts high-level requests (cursor position, cursor shape, control bits, raw write) into one or two correctly timed write cycles with programmable setup, strobe and hold widths. It keeps shadow copies of every written register so the rest of the design can read back the write-only CRTC state. It sits between the system controller and the CRTC register file, on the same clock domain as the controller.

## Interface
- SETUP_CYCLES, 1: cycles that address and data are valid before the falling edge of n_write (minimum 1).
- PULSE_CYCLES, 2: cycles n_write is held low (minimum 1).
- HOLD_CYCLES, 1: cycles that address and data stay valid after the rising edge of n_write (minimum 1).
- clk  in  1  system clock; all outputs registered on its rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_kind  in  2  0 cursor position, 1 cursor shape, 2 control, 3 raw write.
- req_data  in  16  request payload; encoding under Operation.
- done  out  1  one-cycle pulse when the last write of a request finishes its hold phase.
- cpu_data  out  8  write data to the register bus.
- cpu_address  out  2  register select.
- n_write  out  1  active-low write strobe; the register latches on its rising edge.
- data_oe  out  1  high while the block drives cpu_data (SETUP, PULSE and HOLD).
- shadow_match_address  out  11  last written cursor address.
- shadow_cursor_disable  out  1  last written cursor disable bit.
- shadow_start_scanline, shadow_end_scanline  out  4 each  last written cursor scanlines.
- shadow_screen_blank, shadow_extended_bg_colours  out  1 each  last written control bits.

## Operation
- A request is accepted on a rising clk edge when req_valid and req_ready are both high. The payload is captured into internal registers on acceptance. req_data may change afterwards.
- Payload encoding:
  - kind 0: two writes. First, reg0 = {req_data[15], 4'b0, req_data[10:8]}. Second, reg1 = req_data[7:0].
  - kind 1: one write, reg2 = req_data[7:0] (end scanline in [7:4], start scanline in [3:0]).
  - kind 2: one write, reg3 = {3'b0, req_data[4], 3'b0, req_data[0]}.
  - kind 3: one write, address req_data[9:8], data req_data[7:0].
- State machine states: IDLE, SETUP, PULSE, HOLD.
  - IDLE -> SETUP on acceptance.
  - SETUP -> PULSE after SETUP_CYCLES.
  - PULSE -> HOLD after PULSE_CYCLES.
  - HOLD -> SETUP after HOLD_CYCLES if a second write is pending (address and data change on entry to SETUP).
  - HOLD -> IDLE after HOLD_CYCLES otherwise; done pulses in the last HOLD cycle.
- Outputs per state:
  - n_write is 0 only in PULSE.
  - data_oe is 1 in SETUP, PULSE and HOLD.
  - In IDLE, cpu_data and cpu_address keep their last values and data_oe is 0.
- Shadow update: the shadow field for the target register updates on the PULSE->HOLD transition, i.e. coincident with the rising edge of n_write. Raw writes update the shadow field(s) for their address using the same bit mapping as kinds 0-2.
- Phase lengths use a single down-counter reloaded at each state entry, sized for max(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES).

## Timing
- Reset values:
  - Bus and handshake outputs: n_write 1, data_oe 0, cpu_data 0, cpu_address 0, req_ready 1 (IDLE), done 0.
  - Shadows match the register file defaults: match_address 0, cursor_disable 0, start_scanline 13, end_scanline 14, screen_blank 0, extended_bg_colours 0.
- Single write length is SETUP_CYCLES + PULSE_CYCLES + HOLD_CYCLES cycles after acceptance, plus one IDLE cycle before the next acceptance. With defaults this is 4 cycles busy, and req_ready returns 5 cycles after the acceptance edge.
- Cursor position request: with defaults, 8 busy cycles; the reg0 hold phase is followed directly by the reg1 setup phase.
- n_write never falls in the same cycle that cpu_address or cpu_data changes; both are stable for the entire PULSE and HOLD phases.
- Reset asserted mid-operation: all outputs go to their reset values immediately (n_write forced high) and the request is dropped with no done pulse. The register file is reset by the same signal, so the shadows stay consistent.
- req_valid held high continuously: requests are serviced back-to-back, one IDLE cycle apart.

## Test plan
- Reset, then kind 1 with req_data=0x0053 (defaults) -> n_write low during cycles 2-3 after acceptance, cpu_address=2, cpu_data=0x53; done in cycle 4; shadows end=5, start=3; req_ready high in cycle 5.
- Kind 0 with req_data=0x8567 -> first write reg0=0x85, then reg1=0x67; shadow_match_address=0x567, shadow_cursor_disable=1; 8 busy cycles.
- Kind 2 with req_data=0x0011 and SETUP=3, PULSE=4, HOLD=2 -> cpu_address=3, data 0x11, phase lengths exactly 3/4/2; shadows blank=1, ext=1.
- Back-to-back: kind 3 (0x0142) then kind 3 (0x0299) with req_valid held high -> two write cycles separated by one IDLE cycle; second accepted exactly once.
- Reset asserted during PULSE of a kind 0 request -> n_write high and data_oe low in the same cycle; shadows return to defaults; no done pulse; next request completes normally.
- Bus checker throughout all tests: cpu_address and cpu_data never change while n_write=0 or during HOLD.
